// File: rtl/tlul_host_arb2.sv
// Two-host to one-device TL-UL arbiter: round-robin grant, one outstanding
// transaction, D-channel routing and a timeout-synthesized error response.
package tlul_pkg;
    localparam logic [2:0] AccessAck     = 3'h0;
    localparam logic [2:0] AccessAckData = 3'h1;
    localparam logic [2:0] Get           = 3'h4;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_arb2
    import tlul_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntW          = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  tl_h2d_t    tl_h0_i,
    output tl_d2h_t    tl_h0_o,
    input  tl_h2d_t    tl_h1_i,
    output tl_d2h_t    tl_h1_o,
    output tl_h2d_t    tl_dev_o,
    input  tl_d2h_t    tl_dev_i,
    output logic [1:0] grant_o,
    output logic       timeout_o
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_e;

    localparam int unsigned CntLastInt = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
    localparam logic [CntW-1:0] CntLast = CntLastInt[CntW-1:0];

    state_e          state_q;
    logic [1:0]      grant_q;
    logic            last_q;
    logic [CntW-1:0] cnt_q;
    logic            stale_q;
    logic [7:0]      src_q;
    logic            timeout_q;

    logic    gsel;
    logic    pick1;
    tl_h2d_t req_sel;
    tl_d2h_t rsp;

    assign gsel    = grant_q[1];
    assign req_sel = gsel ? tl_h1_i : tl_h0_i;
    // last_q holds the index of the host served last; the other one wins a tie.
    assign pick1   = tl_h1_i.a_valid && (!tl_h0_i.a_valid || !last_q);

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    always_comb begin
        tl_dev_o = '0;
        rsp      = '0;
        tl_h0_o  = '0;
        tl_h1_o  = '0;
        case (state_q)
            ADDR: begin
                tl_dev_o      = req_sel;
                rsp.a_ready   = tl_dev_i.a_ready;
            end
            DATA: begin
                tl_dev_o.d_ready = req_sel.d_ready;
                rsp              = tl_dev_i;
                rsp.a_ready      = 1'b0;
            end
            ERR: begin
                rsp.d_valid  = 1'b1;
                rsp.d_opcode = AccessAckData;
                rsp.d_error  = 1'b1;
                rsp.d_size   = 2'd2;
                rsp.d_source = src_q;
            end
            default: begin
                // Drains the reply the device still owes after a timeout.
                tl_dev_o.d_ready = stale_q;
            end
        endcase
        if (gsel) begin
            tl_h1_o = rsp;
        end else begin
            tl_h0_o = rsp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            stale_q   <= 1'b0;
            src_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (stale_q) begin
                        if (tl_dev_i.d_valid) begin
                            stale_q <= 1'b0;
                        end
                    end else if (tl_h0_i.a_valid || tl_h1_i.a_valid) begin
                        grant_q <= pick1 ? 2'b10 : 2'b01;
                        src_q   <= pick1 ? tl_h1_i.a_source : tl_h0_i.a_source;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (req_sel.a_valid && tl_dev_i.a_ready) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                    end
                end
                DATA: begin
                    if (tl_dev_i.d_valid && req_sel.d_ready) begin
                        last_q  <= gsel;
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end else begin
                        // A d_valid on the threshold cycle suppresses the timeout.
                        if (!tl_dev_i.d_valid && (TimeoutCycles != 0) && (cnt_q == CntLast)) begin
                            state_q   <= ERR;
                            stale_q   <= 1'b1;
                            timeout_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ERR: begin
                    if (req_sel.d_ready) begin
                        last_q  <= gsel;
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tlul_host_arb2.sv
// Bench for tlul_host_arb2: table of transactions, reset corner cases and a
// randomized phase checked against a round-robin reference model.
module tb_tlul_host_arb2;
    import tlul_pkg::*;

    localparam logic [7:0] Src0 = 8'h10;
    localparam logic [7:0] Src1 = 8'h21;
    localparam int NoResp = 100;

    logic       clk = 1'b0;
    logic       rst;
    tl_h2d_t    h0_i, h1_i, dev_o;
    tl_d2h_t    h0_o, h1_o, dev_i;
    logic [1:0] grant;
    logic       timeout;

    int checks = 0;
    int failures = 0;
    int m_last;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        int          rdly;
        int          pdly;
        logic [31:0] rd;
        int          exp_g;
    } vec_t;
    vec_t vecs[10];

    tlul_host_arb2 #(.TimeoutCycles(8), .CntW(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .tl_h0_i(h0_i), .tl_h0_o(h0_o),
        .tl_h1_i(h1_i), .tl_h1_o(h1_o),
        .tl_dev_o(dev_o), .tl_dev_i(dev_i),
        .grant_o(grant), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tl_d2h_t rsp_of(input int h);
        return (h == 1) ? h1_o : h0_o;
    endfunction

    // Round-robin rule: a lone requester wins; on a tie the host not served last wins.
    function automatic int model_pick(input logic [1:0] req);
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        return (m_last == 1) ? 0 : 1;
    endfunction

    task automatic run_txn(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                           input int rdly, input int pdly, input logic [31:0] rd, input int g);
        int w;
        int o;
        logic [31:0] ea;
        logic [7:0] es;
        o  = 1 - g;
        ea = (g == 1) ? a1 : a0;
        es = (g == 1) ? Src1 : Src0;
        @(posedge clk); #1;
        h0_i.a_valid = req[0]; h0_i.a_address = a0;
        h1_i.a_valid = req[1]; h1_i.a_address = a1;
        dev_i.a_ready = (rdly == 0);
        dev_i.d_valid = 1'b0;
        w = 0;
        @(negedge clk);
        while (grant == 2'b00 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("grant", grant, 2'b01 << g);
        check("grant_latency", w, 1);
        if (grant == 2'b00) return;
        check("dev_a_valid", dev_o.a_valid, 1);
        check("dev_a_address", dev_o.a_address, ea);
        check("dev_a_source", dev_o.a_source, es);
        check("a_ready_gnt", rsp_of(g).a_ready, rdly == 0);
        check("a_ready_oth", rsp_of(o).a_ready, 0);
        for (int i = 1; i <= rdly; i++) begin
            @(posedge clk); #1;
            dev_i.a_ready = (i == rdly);
            @(negedge clk);
            check("a_ready_gnt", rsp_of(g).a_ready, i == rdly);
            check("a_ready_oth", rsp_of(o).a_ready, 0);
        end
        @(posedge clk); #1;
        if (g == 0) h0_i.a_valid = 1'b0; else h1_i.a_valid = 1'b0;
        dev_i.a_ready  = 1'b0;
        dev_i.d_data   = rd;
        dev_i.d_source = es;
        dev_i.d_opcode = AccessAckData;
        dev_i.d_size   = 2'd2;
        dev_i.d_error  = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            dev_i.d_valid = (c == pdly);
            @(negedge clk);
            if (c == pdly) begin
                check("rsp_d_valid", rsp_of(g).d_valid, 1);
                check("rsp_d_data", rsp_of(g).d_data, rd);
                check("rsp_d_error", rsp_of(g).d_error, 0);
                check("rsp_d_source", rsp_of(g).d_source, es);
                check("rsp_oth_d_valid", rsp_of(o).d_valid, 0);
                check("rsp_timeout", timeout, 0);
                check("dev_d_ready", dev_o.d_ready, 1);
                break;
            end else if (c == 8) begin
                check("err_d_valid", rsp_of(g).d_valid, 1);
                check("err_d_error", rsp_of(g).d_error, 1);
                check("err_d_data", rsp_of(g).d_data, 0);
                check("err_d_opcode", rsp_of(g).d_opcode, AccessAckData);
                check("err_d_size", rsp_of(g).d_size, 2);
                check("err_d_source", rsp_of(g).d_source, es);
                check("err_oth_d_valid", rsp_of(o).d_valid, 0);
                check("err_timeout", timeout, 1);
            end else begin
                check("wait_d_valid", rsp_of(g).d_valid, 0);
                check("wait_oth_d_valid", rsp_of(o).d_valid, 0);
                check("wait_dev_a_valid", dev_o.a_valid, 0);
                check("wait_timeout", timeout, 0);
            end
        end
        @(posedge clk); #1;
        dev_i.d_valid = 1'b0;
        h0_i.a_valid  = 1'b0;
        h1_i.a_valid  = 1'b0;
        m_last = g;
        @(negedge clk);
        check("done_grant", grant, 0);
        check("done_timeout", timeout, 0);
        if (pdly >= 8) begin
            // Both hosts ask while the late reply is still owed: nothing is granted.
            h0_i.a_valid = 1'b1;
            h1_i.a_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check("stale_grant", grant, 0);
                check("stale_dev_d_ready", dev_o.d_ready, 1);
            end
            h0_i.a_valid  = 1'b0;
            h1_i.a_valid  = 1'b0;
            dev_i.d_valid = 1'b1;
            dev_i.d_data  = 32'h1234;
            #1;
            check("late_h0_d_valid", h0_o.d_valid, 0);
            check("late_h1_d_valid", h1_o.d_valid, 0);
            check("late_dev_d_ready", dev_o.d_ready, 1);
            @(posedge clk); #1;
            dev_i.d_valid = 1'b0;
            @(negedge clk);
            check("drained_dev_d_ready", dev_o.d_ready, 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_dev_a_valid"}, dev_o.a_valid, 0);
        check({tag, "_dev_d_ready"}, dev_o.d_ready, 0);
        check({tag, "_h0_a_ready"}, h0_o.a_ready, 0);
        check({tag, "_h1_a_ready"}, h1_o.a_ready, 0);
        check({tag, "_h0_d_valid"}, h0_o.d_valid, 0);
        check({tag, "_h1_d_valid"}, h1_o.d_valid, 0);
    endtask

    initial begin
        int w;
        vecs[0] = '{2'b11, 32'h4,        32'h1000, 0, 1,      32'hA0A0_0001, 0};
        vecs[1] = '{2'b11, 32'h4,        32'h1000, 0, 1,      32'hA0A0_0002, 1};
        vecs[2] = '{2'b11, 32'h4,        32'h1000, 0, 1,      32'hA0A0_0003, 0};
        vecs[3] = '{2'b11, 32'h4,        32'h1000, 0, 1,      32'hA0A0_0004, 1};
        vecs[4] = '{2'b01, 32'h0,        32'h0,    0, 2,      32'hDEAD_BEEF, 0};
        vecs[5] = '{2'b11, 32'h40,       32'h2000, 3, 1,      32'h5555_AAAA, 1};
        vecs[6] = '{2'b10, 32'h0,        32'h3000, 0, 7,      32'hCAFE_F00D, 1};
        vecs[7] = '{2'b11, 32'h50,       32'h60,   0, NoResp, 32'h0BAD_0BAD, 0};
        vecs[8] = '{2'b11, 32'h70,       32'h80,   1, 0,      32'h1357_9BDF, 1};
        vecs[9] = '{2'b01, 32'hFFFF_FFFC, 32'h0,   2, 3,      32'h0246_8ACE, 0};

        h0_i = '0; h0_i.d_ready = 1'b1; h0_i.a_source = Src0; h0_i.a_opcode = Get;
        h0_i.a_size = 2'd2; h0_i.a_mask = 4'hF;
        h1_i = h0_i; h1_i.a_source = Src1;
        dev_i = '0;
        rst = 1'b1;
        m_last = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        foreach (vecs[i]) begin
            run_txn(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].rdly, vecs[i].pdly,
                    vecs[i].rd, vecs[i].exp_g);
        end

        // Reset while a read is outstanding in DATA.
        @(posedge clk); #1;
        h0_i.a_valid = 1'b1; h0_i.a_address = 32'h8; dev_i.a_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (grant == 2'b00 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_seq_grant", grant, 2'b01);
        @(posedge clk); #1;
        h0_i.a_valid = 1'b0; dev_i.a_ready = 1'b0;
        @(negedge clk);
        check("rst_seq_data_d_ready", dev_o.d_ready, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_last = 1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        run_txn(2'b11, 32'hC, 32'hC00, 0, 1, 32'h7777_0000, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] req;
            int rdly, pdly, g;
            req  = 2'($urandom_range(1, 3));
            rdly = $urandom_range(0, 3);
            pdly = ($urandom_range(0, 5) == 0) ? NoResp : $urandom_range(0, 7);
            g    = model_pick(req);
            run_txn(req, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, rdly, pdly, $urandom, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
